// File: rtl/speed_ctrl_pkg.sv
// Shared types and default constants for the speed ramp sequencer.
package speed_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    BRAKE,
    REVERSE
  } state_t;

  localparam int          DEF_STEP_DIV    = 1000;
  localparam logic [15:0] DEF_STOP_PERIOD = 16'hFFFF;
  localparam logic [15:0] DEF_MIN_PERIOD  = 16'd4;

endpackage

// File: rtl/ramp_tick.sv
// Free-running prescaler that produces the ramp time base.
module ramp_tick #(
  parameter int STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick marks the last count of each period; the counter wraps on it.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register; only reset clears it, commands never do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Command sequencer for the quadrature speed generator: ramps the period
// toward a target, brakes to standstill and reverses on direction change.
module speed_ramp_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int          PW          = 16,
  parameter int          STEP_DIV    = DEF_STEP_DIV,
  parameter logic [PW-1:0] STOP_PERIOD = PW'(DEF_STOP_PERIOD),
  parameter logic [PW-1:0] MIN_PERIOD  = PW'(DEF_MIN_PERIOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [PW-1:0] cmd_period,
  input  logic          cmd_dir,
  input  logic [PW-1:0] cmd_step,
  output logic [PW-1:0] sq,
  output logic          dir,
  output logic          spd_rst,
  output logic          busy,
  output logic          at_target
);

  state_t        state_q, state_d;
  logic [PW-1:0] sq_q, sq_d;
  logic          dir_q, dir_d;
  logic          spd_rst_q;
  logic          at_target_q;
  logic [PW-1:0] tgt_q, tgt_d;
  logic          tdir_q, tdir_d;
  logic [PW-1:0] stp_q, stp_d;
  logic          stop_req_q, stop_req_d;

  logic          tick;
  logic          accept;
  logic          cmd_stop;
  logic [PW-1:0] cmd_tgt;
  logic [PW-1:0] cmd_stp;

  ramp_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // One ramp step toward tgt; differences are taken one bit wider so
  // neither direction can wrap or overshoot the target.
  function automatic logic [PW-1:0] rampStep(input logic [PW-1:0] cur,
                                             input logic [PW-1:0] tgt,
                                             input logic [PW-1:0] stp);
    logic [PW:0] diff;
    rampStep = cur;
    if (cur > tgt) begin
      diff     = {1'b0, cur} - {1'b0, tgt};
      rampStep = (diff > {1'b0, stp}) ? cur - stp : tgt;
    end else if (cur < tgt) begin
      diff     = {1'b0, tgt} - {1'b0, cur};
      rampStep = (diff > {1'b0, stp}) ? cur + stp : tgt;
    end
  endfunction

  // Normalise an offered command: zero period means stop, out-of-range
  // periods are clamped, and a zero step still makes progress.
  always_comb begin
    accept   = cmd_valid && cmd_ready;
    cmd_stop = (cmd_period == '0);
    if (cmd_stop)                     cmd_tgt = STOP_PERIOD;
    else if (cmd_period < MIN_PERIOD) cmd_tgt = MIN_PERIOD;
    else if (cmd_period > STOP_PERIOD) cmd_tgt = STOP_PERIOD;
    else                              cmd_tgt = cmd_period;
    cmd_stp = (cmd_step == '0) ? PW'(1) : cmd_step;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and ramp arithmetic; an accepted command always takes
  // priority over a coincident tick, so that tick's step is skipped.
  always_comb begin
    state_d    = state_q;
    sq_d       = sq_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    tdir_d     = tdir_q;
    stp_d      = stp_q;
    stop_req_d = stop_req_q;
    case (state_q)
      IDLE: begin
        if (accept && !cmd_stop) begin
          tgt_d      = cmd_tgt;
          tdir_d     = cmd_dir;
          stp_d      = cmd_stp;
          stop_req_d = 1'b0;
          dir_d      = cmd_dir;
          state_d    = RAMP;
        end
      end
      RAMP: begin
        if (accept) begin
          tgt_d      = cmd_tgt;
          tdir_d     = cmd_dir;
          stp_d      = cmd_stp;
          stop_req_d = cmd_stop;
          if (cmd_dir != dir_q) state_d = BRAKE;
        end else if (tick) begin
          sq_d = rampStep(sq_q, tgt_q, stp_q);
          if (sq_d == tgt_q) state_d = stop_req_q ? BRAKE : HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          tgt_d      = cmd_tgt;
          tdir_d     = cmd_dir;
          stp_d      = cmd_stp;
          stop_req_d = cmd_stop;
          state_d    = (cmd_stop || cmd_dir != dir_q) ? BRAKE : RAMP;
        end
      end
      BRAKE: begin
        if (tick) begin
          sq_d = rampStep(sq_q, STOP_PERIOD, stp_q);
          if (sq_d == STOP_PERIOD) begin
            if (stop_req_q) begin
              state_d = IDLE;
            end else begin
              state_d = REVERSE;
              dir_d   = tdir_q;
            end
          end
        end
      end
      REVERSE: begin
        state_d = RAMP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered generator controls; reset and the reversal
  // cycle hold the generator in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q        <= STOP_PERIOD;
      dir_q       <= 1'b0;
      spd_rst_q   <= 1'b1;
      at_target_q <= 1'b0;
      tgt_q       <= '0;
      tdir_q      <= 1'b0;
      stp_q       <= '0;
      stop_req_q  <= 1'b0;
    end else begin
      sq_q        <= sq_d;
      dir_q       <= dir_d;
      spd_rst_q   <= (state_d == IDLE) || (state_d == REVERSE);
      at_target_q <= (state_d == HOLD);
      tgt_q       <= tgt_d;
      tdir_q      <= tdir_d;
      stp_q       <= stp_d;
      stop_req_q  <= stop_req_d;
    end
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    cmd_ready = (state_q == IDLE) || (state_q == RAMP) || (state_q == HOLD);
    sq        = sq_q;
    dir       = dir_q;
    spd_rst   = spd_rst_q;
    at_target = at_target_q;
  end

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Self-checking bench for speed_ramp_ctrl with a fast ramp time base.
module tb_speed_ramp_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_period;
  logic        cmd_dir;
  logic [15:0] cmd_step;
  logic [15:0] sq;
  logic        dir;
  logic        spd_rst;
  logic        busy;
  logic        at_target;

  int checks = 0;
  int passes = 0;
  int edgeCnt;
  int expQ[$];

  typedef struct {
    int              period;
    bit              dir;
    int              step;
    int              n;
    logic [0:2][15:0] exp;
  } vec_t;

  vec_t vecs[6];

  speed_ramp_ctrl #(
    .PW          (16),
    .STEP_DIV    (DIV),
    .STOP_PERIOD (16'd100),
    .MIN_PERIOD  (16'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_dir    (cmd_dir),
    .cmd_step   (cmd_step),
    .sq         (sq),
    .dir        (dir),
    .spd_rst    (spd_rst),
    .busy       (busy),
    .at_target  (at_target)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Independent count of clock edges since reset; ramp ticks act on every
  // DIV-th edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic waitTick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      @(posedge clk);
      #1;
      if (edgeCnt % DIV == 0) found = 1'b1;
    end
    if (!found) checkOutput("tick timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int p, input bit d, input int s, input bit onTick);
    @(negedge clk);
    if (onTick)
      for (int i = 0; i < 2 * DIV && (edgeCnt % DIV) != DIV - 1; i++) @(negedge clk);
    cmd_period = 16'(p);
    cmd_dir    = d;
    cmd_step   = 16'(s);
    cmd_valid  = 1'b1;
    checkOutput("cmd_ready at offer", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic runSteps(input int n, input bit finalHold);
    for (int i = 0; i < n; i++) begin
      waitTick();
      if (expQ.size() == 0) checkOutput("scoreboard empty", 0, 1);
      else checkOutput("sq step", sq, expQ.pop_front());
      checkOutput("at_target", at_target, (finalHold && i == n - 1) ? 1 : 0);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{period: 40,  dir: 1'b0, step: 20, n: 3, exp: {16'd80, 16'd60, 16'd40}};
    vecs[1] = '{period: 50,  dir: 1'b0, step: 20, n: 1, exp: {16'd50, 16'd0,  16'd0}};
    vecs[2] = '{period: 90,  dir: 1'b0, step: 15, n: 3, exp: {16'd65, 16'd80, 16'd90}};
    vecs[3] = '{period: 3,   dir: 1'b0, step: 50, n: 2, exp: {16'd40, 16'd4,  16'd0}};
    vecs[4] = '{period: 200, dir: 1'b0, step: 60, n: 2, exp: {16'd64, 16'd100, 16'd0}};
    vecs[5] = '{period: 50,  dir: 1'b0, step: 25, n: 2, exp: {16'd75, 16'd50, 16'd0}};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_period = '0;
    cmd_dir    = 1'b0;
    cmd_step   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset sq", sq, 100);
    checkOutput("reset spd_rst", spd_rst, 1);
    checkOutput("reset dir", dir, 0);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset at_target", at_target, 0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].period, vecs[v].dir, vecs[v].step, 1'b0);
      checkOutput("spd_rst after accept", spd_rst, 0);
      checkOutput("busy after accept", busy, 1);
      for (int j = 0; j < vecs[v].n; j++) expQ.push_back(int'(vecs[v].exp[j]));
      runSteps(vecs[v].n, 1'b1);
      checkOutput("dir in hold", dir, vecs[v].dir);
    end

    applyStimulus(40, 1'b1, 20, 1'b0);
    expQ.push_back(70);
    expQ.push_back(90);
    expQ.push_back(100);
    for (int i = 0; i < 3; i++) begin
      waitTick();
      checkOutput("brake sq", sq, expQ.pop_front());
      checkOutput("brake cmd_ready", cmd_ready, 0);
    end
    checkOutput("reverse spd_rst", spd_rst, 1);
    checkOutput("reverse dir", dir, 1);
    @(posedge clk);
    #1;
    checkOutput("after reverse spd_rst", spd_rst, 0);
    checkOutput("after reverse cmd_ready", cmd_ready, 1);
    checkOutput("after reverse sq", sq, 100);
    expQ.push_back(80);
    expQ.push_back(60);
    expQ.push_back(40);
    runSteps(3, 1'b1);

    applyStimulus(0, 1'b0, 20, 1'b0);
    expQ.push_back(60);
    expQ.push_back(80);
    expQ.push_back(100);
    runSteps(3, 1'b0);
    checkOutput("stop busy", busy, 0);
    checkOutput("stop spd_rst", spd_rst, 1);
    checkOutput("stop dir kept", dir, 1);

    applyStimulus(0, 1'b0, 5, 1'b0);
    checkOutput("idle stop busy", busy, 0);
    checkOutput("idle stop spd_rst", spd_rst, 1);
    checkOutput("idle stop dir", dir, 1);

    applyStimulus(2, 1'b0, 0, 1'b0);
    checkOutput("direct dir", dir, 0);
    checkOutput("direct spd_rst", spd_rst, 0);
    expQ.push_back(99);
    expQ.push_back(98);
    expQ.push_back(97);
    runSteps(3, 1'b0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset sq", sq, 100);
    checkOutput("async reset spd_rst", spd_rst, 1);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("after release sq", sq, 100);

    applyStimulus(40, 1'b0, 20, 1'b0);
    expQ.push_back(80);
    runSteps(1, 1'b0);
    applyStimulus(30, 1'b0, 20, 1'b1);
    checkOutput("no step on accept tick", sq, 80);
    expQ.push_back(60);
    expQ.push_back(40);
    expQ.push_back(30);
    runSteps(3, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
